mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined CPU, between the EX/MEM register and the MEM/WB register. Holds the word-addressed data memory, runs each load/store for a fixed multi-cycle latency, and raises `stall_o` so upstream stages freeze. Forwards writeback control, ALU result, destination register and load data to the MEM/WB register. Injects a bubble (RegWrite forced low) in every stalled cycle.

## Interface
Parameters:
- `DEPTH`, 256: data memory size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 3: cycles per memory access, 1..8.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `MemRead_i`  in  1  load request (from EX/MEM).
- `MemWrite_i`  in  1  store request (from EX/MEM).
- `RegWrite_i`  in  1  writeback enable of the instruction in MEM.
- `MemtoReg_i`  in  1  writeback select of the instruction in MEM.
- `ALUResult_i`  in  32  byte address for loads/stores; ALU result otherwise.
- `Wdata_i`  in  32  store data.
- `RDaddr_i`  in  5  destination register.
- `RegWrite_o`  out  1  `RegWrite_i & ~stall_o`; to MEM/WB.
- `MemtoReg_o`  out  1  `MemtoReg_i` pass-through.
- `ALUResult_o`  out  32  `ALUResult_i` pass-through.
- `Memdata_o`  out  32  load data; 0 when no load completes this cycle.
- `RDaddr_o`  out  5  `RDaddr_i` pass-through.
- `stall_o`  out  1  high: freeze PC, IF/ID, ID/EX, EX/MEM; hold all inputs stable.
- `misalign_o`  out  1  request present and `ALUResult_i[1:0] != 0`.

## Operation
- Request = `MemRead_i | MemWrite_i`. If both are high, the access is a store; `Memdata_o = 0`.
- Word index = `ALUResult_i[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned request: no memory write, `Memdata_o = 0`, `stall_o = 0`, completes in 1 cycle, `misalign_o = 1`.
- FSM states: IDLE, WAIT. Down-counter `cnt`, width ≥ 3.
  - IDLE, no request: stay.
  - IDLE, aligned request, LATENCY = 1: completes this cycle. `stall_o = 0`. Store commits at the edge; load data appears on `Memdata_o` combinationally.
  - IDLE, aligned request, LATENCY > 1: `stall_o = 1`. Go to WAIT with `cnt = LATENCY-2`.
  - WAIT, `cnt != 0`: `stall_o = 1`, decrement `cnt`.
  - WAIT, `cnt == 0` (final cycle): `stall_o = 0`. Load drives `Memdata_o = mem[index]`; store commits `Wdata_i` at the closing edge. Go to IDLE.
- Next instruction: a new request seen in IDLE on the cycle after a final cycle starts a fresh access. Back-to-back accesses have no idle gap.
- Load after store to the same word: returns the newly stored value.
- Non-final cycles: `Memdata_o = 0`.

## Timing
- Aligned access occupies exactly LATENCY cycles.
- `stall_o` is high for the first LATENCY-1 of those cycles and low in the last.
- MEM/WB captures valid load data and `RegWrite_o` at the edge that closes the final cycle.
- `stall_o`, `RegWrite_o`, `Memdata_o`, `misalign_o` are combinational from state and inputs. The three pass-through outputs are purely combinational.
- Reset asserted, including mid-access:
  - State IDLE, `cnt = 0`, all memory words cleared to 0.
  - Any pending store is discarded.
  - While `rst_i` is high: `stall_o = 0`, `RegWrite_o = 0`, `Memdata_o = 0`, `misalign_o = 0`.
- After reset release, a request still present is treated as a new access starting in that cycle.
- Inputs changing while `stall_o` is high is illegal upstream behaviour. The result is unspecified; the bench must not drive it.

## Test plan
- LATENCY=3. Store 0xDEADBEEF to 0x10, then load 0x10 with RegWrite_i=1, RDaddr_i=5 → each access: `stall_o` 1,1,0. `RegWrite_o` 0,0,1. Load final cycle: `Memdata_o` = 0xDEADBEEF, `RDaddr_o` = 5.
- LATENCY=1. Store 0x1 to 0x0, then load 0x0 back-to-back → `stall_o` never high. Load cycle: `Memdata_o` = 0x1.
- Load from 0x402 (misaligned) → `misalign_o` = 1, `stall_o` = 0, `Memdata_o` = 0, memory unchanged.
- DEPTH=256. Store 0xA5 to 0x400, load 0x0 → 0xA5 (wrap-around).
- Non-memory instruction, RegWrite_i=1, ALUResult_i=0x1234 → same cycle: `RegWrite_o` = 1, `ALUResult_o` = 0x1234, `Memdata_o` = 0, `stall_o` = 0.
- LATENCY=4. Store 0x55 to 0x8; assert `rst_i` in the 2nd cycle; release; load 0x8 → returns 0. `stall_o` and `RegWrite_o` are 0 while in reset.

Source files
------------

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory-access stage with multi-cycle data memory,
//            upstream stall generation and MEM/WB forwarding.
// Revision : 1.0
// ============================================================================
module mem_stage #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] Wdata_i,
   input  logic [4:0]  RDaddr_i,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic [31:0] ALUResult_o,
   output logic [31:0] Memdata_o,
   output logic [4:0]  RDaddr_o,
   output logic        stall_o,
   output logic        misalign_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = 3;
   localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [31:0]      mem [DEPTH];

   logic             req;
   logic             misaligned;
   logic             aligned;
   logic             is_load;
   logic             final_cycle;
   logic             stall;
   logic             do_store;
   logic [AW-1:0]    idx;
   logic             unused_addr;

   assign req         = MemRead_i | MemWrite_i;
   assign misaligned  = req & (ALUResult_i[1:0] != 2'b00);
   assign aligned     = req & ~misaligned;
   assign is_load     = MemRead_i & ~MemWrite_i;
   assign idx         = ALUResult_i[AW+1:2];
   // Upper address bits deliberately ignored: the memory wraps modulo DEPTH words.
   assign unused_addr = ^ALUResult_i[31:AW+2];

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      stall       = 1'b0;
      final_cycle = 1'b0;
      case (state)
         S_IDLE: begin
            if (aligned) begin
               if (LATENCY == 1) begin
                  final_cycle = 1'b1;
               end else begin
                  stall    = 1'b1;
                  state_nx = S_WAIT;
                  cnt_nx   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt != '0) begin
               stall  = 1'b1;
               cnt_nx = cnt - 1'b1;
            end else begin
               final_cycle = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   assign do_store = final_cycle & MemWrite_i;

   // Reset clears the whole array, so a store in flight is simply lost.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_store) begin
         mem[idx] <= Wdata_i;
      end
   end

   assign stall_o     = stall & ~rst_i;
   assign RegWrite_o  = RegWrite_i & ~stall & ~rst_i;
   assign misalign_o  = misaligned & ~rst_i;
   assign Memdata_o   = (final_cycle & is_load & ~rst_i) ? mem[idx] : 32'd0;
   assign MemtoReg_o  = MemtoReg_i;
   assign ALUResult_o = ALUResult_i;
   assign RDaddr_o    = RDaddr_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Scoreboard bench for mem_stage at LATENCY 3, 1 and 4.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

   localparam int NDUT = 3;

   logic        clk;
   logic        rst      [NDUT];
   logic        mrd      [NDUT];
   logic        mwr      [NDUT];
   logic        rwe      [NDUT];
   logic        m2r      [NDUT];
   logic [31:0] alu      [NDUT];
   logic [31:0] wd       [NDUT];
   logic [4:0]  rda      [NDUT];
   logic        rwe_o    [NDUT];
   logic        m2r_o    [NDUT];
   logic [31:0] alu_o    [NDUT];
   logic [31:0] md_o     [NDUT];
   logic [4:0]  rda_o    [NDUT];
   logic        stall_o  [NDUT];
   logic        mis_o    [NDUT];

   typedef struct {
      logic [31:0] md;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        m2r;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model [NDUT][256];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 3 : (d == 1) ? 1 : 4;
   endfunction

   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         mem_stage #(
            .DEPTH   (256),
            .LATENCY ((g == 0) ? 3 : (g == 1) ? 1 : 4)
         ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .MemRead_i   (mrd[g]),
            .MemWrite_i  (mwr[g]),
            .RegWrite_i  (rwe[g]),
            .MemtoReg_i  (m2r[g]),
            .ALUResult_i (alu[g]),
            .Wdata_i     (wd[g]),
            .RDaddr_i    (rda[g]),
            .RegWrite_o  (rwe_o[g]),
            .MemtoReg_o  (m2r_o[g]),
            .ALUResult_o (alu_o[g]),
            .Memdata_o   (md_o[g]),
            .RDaddr_o    (rda_o[g]),
            .stall_o     (stall_o[g]),
            .misalign_o  (mis_o[g])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs(input int d);
      mrd[d] = 1'b0; mwr[d] = 1'b0; rwe[d] = 1'b0; m2r[d] = 1'b0;
      alu[d] = '0;   wd[d]  = '0;   rda[d] = '0;
   endtask

   task automatic clear_model(input int d);
      for (int i = 0; i < 256; i++) model[d][i] = '0;
   endtask

   // Drives one instruction into DUT d, checks every cycle it occupies.
   task automatic access(input int d, input bit rdq, input bit wrq, input bit rw,
                         input bit mr, input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] r);
      bit          req, misal, algn, exp_st;
      int          n;
      logic [7:0]  idx;
      exp_t        e;
      req   = rdq | wrq;
      misal = req && (a[1:0] != 2'b00);
      algn  = req && !misal;
      idx   = a[9:2];
      n     = algn ? lat_of(d) : 1;
      e.md  = (algn && rdq && !wrq) ? model[d][idx] : 32'd0;
      e.alu = a;
      e.rd  = r;
      e.m2r = mr;
      sb.push_back(e);
      mrd[d] = rdq; mwr[d] = wrq; rwe[d] = rw; m2r[d] = mr;
      alu[d] = a;   wd[d]  = w;   rda[d] = r;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         exp_st = (k < n - 1);
         check($sformatf("d%0d_a%h_stall_c%0d", d, a, k), 32'(stall_o[d]), 32'(exp_st));
         check($sformatf("d%0d_a%h_regwr_c%0d", d, a, k), 32'(rwe_o[d]), 32'(rw & !exp_st));
         check($sformatf("d%0d_a%h_misal_c%0d", d, a, k), 32'(mis_o[d]), 32'(misal));
         if (k == n - 1) begin
            e = sb.pop_front();
            check($sformatf("d%0d_a%h_memdata", d, a), md_o[d], e.md);
            check($sformatf("d%0d_a%h_aluout", d, a), alu_o[d], e.alu);
            check($sformatf("d%0d_a%h_rdaddr", d, a), 32'(rda_o[d]), 32'(e.rd));
            check($sformatf("d%0d_a%h_m2r", d, a), 32'(m2r_o[d]), 32'(e.m2r));
         end else begin
            check($sformatf("d%0d_a%h_memdata_c%0d", d, a, k), md_o[d], 32'd0);
         end
         @(posedge clk);
         #1;
      end
      if (algn && wrq) model[d][idx] = w;
      idle_inputs(d);
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         rst[d] = 1'b1;
         idle_inputs(d);
         clear_model(d);
      end
      // Request present during reset: outputs must still be quiet.
      mrd[0] = 1'b1; rwe[0] = 1'b1; alu[0] = 32'h11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stall_o[0]), 32'd0);
      check("rst_regwr", 32'(rwe_o[0]), 32'd0);
      check("rst_misal", 32'(mis_o[0]), 32'd0);
      check("rst_memdata", md_o[0], 32'd0);
      @(posedge clk); #1;
      idle_inputs(0);
      for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
      @(negedge clk);
      check("idle_stall", 32'(stall_o[0]), 32'd0);
      check("idle_memdata", md_o[0], 32'd0);
      @(posedge clk); #1;

      // LATENCY 3
      access(0, 0, 1, 0, 0, 32'h10,  32'hDEADBEEF, 5'd0);
      access(0, 1, 0, 1, 1, 32'h10,  32'h0,        5'd5);
      access(0, 1, 0, 1, 1, 32'h402, 32'h0,        5'd6);
      access(0, 0, 1, 0, 0, 32'h12,  32'hBAD0BAD0, 5'd0);
      access(0, 1, 0, 1, 1, 32'h10,  32'h0,        5'd7);
      access(0, 0, 1, 0, 0, 32'h400, 32'hA5,       5'd0);
      access(0, 1, 0, 1, 1, 32'h0,   32'h0,        5'd8);
      access(0, 0, 0, 1, 0, 32'h1234, 32'h0,       5'd9);
      access(0, 1, 1, 1, 0, 32'h20,  32'h99,       5'd10);
      access(0, 1, 0, 1, 1, 32'h20,  32'h0,        5'd11);
      access(0, 1, 0, 1, 1, 32'hFFFF_FC10, 32'h0,  5'd12);

      // LATENCY 1
      access(1, 0, 1, 0, 0, 32'h0,   32'h1,        5'd0);
      access(1, 1, 0, 1, 1, 32'h0,   32'h0,        5'd3);
      access(1, 0, 1, 0, 0, 32'h3FC, 32'hCAFE,     5'd0);
      access(1, 1, 0, 1, 1, 32'h7FC, 32'h0,        5'd4);

      // LATENCY 4, reset in the middle of a store
      access(2, 0, 1, 0, 0, 32'h8,   32'h77,       5'd0);
      access(2, 1, 0, 1, 1, 32'h8,   32'h0,        5'd2);
      mwr[2] = 1'b1; rwe[2] = 1'b1; alu[2] = 32'h8; wd[2] = 32'h55;
      @(negedge clk);
      check("d2_rst_pre_stall", 32'(stall_o[2]), 32'd1);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(negedge clk);
      check("d2_rst_stall", 32'(stall_o[2]), 32'd0);
      check("d2_rst_regwr", 32'(rwe_o[2]), 32'd0);
      check("d2_rst_memdata", md_o[2], 32'd0);
      check("d2_rst_misal", 32'(mis_o[2]), 32'd0);
      @(posedge clk); #1;
      idle_inputs(2);
      @(posedge clk); #1;
      rst[2] = 1'b0;
      clear_model(2);
      access(2, 1, 0, 1, 1, 32'h8,   32'h0,        5'd1);
      access(2, 0, 1, 0, 0, 32'hC,   32'h1234ABCD, 5'd0);
      access(2, 1, 0, 1, 0, 32'hC,   32'h0,        5'd31);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
